// File: rtl/mips_pkg.sv
// Shared definitions for the fetch path.
//   ADDR_W / INSTR_W : address and instruction widths
//   PC_INC           : byte distance between consecutive instructions
//   fq_entry_t       : one fetch-queue entry {instr, pc}
package mips_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fq_entry_t;

  localparam int ENTRY_W = $bits(fq_entry_t);

endpackage

// File: rtl/fq_storage.sv
// Register array backing the fetch queue. No reset: every entry is written
// before it can be read as valid, and the top masks invalid slots.
//   clk_sys           : clock
//   we0 / we1         : write enables for entry wr_addr and wr_addr+1
//   wr_addr           : base write address
//   wr_data0/wr_data1 : entries written at wr_addr / wr_addr+1
//   rd_addr           : base read address
//   rd_data0/rd_data1 : asynchronous reads of rd_addr / rd_addr+1
module fq_storage
  import mips_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk_sys,
  input  logic               we0,
  input  logic               we1,
  input  logic [PTR_W-1:0]   wr_addr,
  input  logic [ENTRY_W-1:0] wr_data0,
  input  logic [ENTRY_W-1:0] wr_data1,
  input  logic [PTR_W-1:0]   rd_addr,
  output logic [ENTRY_W-1:0] rd_data0,
  output logic [ENTRY_W-1:0] rd_data1
);

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_addr1;
  logic [PTR_W-1:0] rd_addr1;

  // Power-of-two depth: +1 wraps naturally in PTR_W bits.
  assign wr_addr1 = wr_addr + PTR_W'(1);
  assign rd_addr1 = rd_addr + PTR_W'(1);

  always_ff @(posedge clk_sys) begin
    if (we0) mem[wr_addr]  <= wr_data0;
    if (we1) mem[wr_addr1] <= wr_data1;
  end

  assign rd_data0 = mem[rd_addr];
  assign rd_data1 = mem[rd_addr1];

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch queue. Owns the fetch PC, enqueues up to
// FETCH_W instructions per cycle from instruction memory, and presents up to
// DRAIN_W in-order instructions to decode, which pops them by count.
// Occupancy is implicit: FILLING while free > 0, FULL when free == 0.
//   CLK, RESET            : clock, async active-low reset
//   Instr_address_2IM     : fetch PC (registered)
//   Instr1_fIM/Instr2_fIM : IM words at PC and PC+4
//   fetch_valid_fIM       : both IM words valid this cycle
//   Request_Alt_PC/Alt_PC : flush and restart fetch at Alt_PC
//   deq_count             : instructions consumed by decode this cycle
//   out_valid             : per-slot valid for the two output slots
//   Instr_OUT0/1, PC_OUT0/1 : head and head+1 (zero when invalid)
//   count                 : occupied entries
module fetch_queue
  import mips_pkg::*;
#(
  parameter int              DEPTH    = 8,
  parameter int              FETCH_W  = 2,
  parameter int              DRAIN_W  = 2,
  parameter logic [31:0]     RESET_PC = 32'hBFC00000
) (
  input  logic                       CLK,
  input  logic                       RESET,
  output logic [ADDR_W-1:0]          Instr_address_2IM,
  input  logic [INSTR_W-1:0]         Instr1_fIM,
  input  logic [INSTR_W-1:0]         Instr2_fIM,
  input  logic                       fetch_valid_fIM,
  input  logic                       Request_Alt_PC,
  input  logic [ADDR_W-1:0]          Alt_PC,
  input  logic [1:0]                 deq_count,
  output logic [1:0]                 out_valid,
  output logic [INSTR_W-1:0]         Instr_OUT0,
  output logic [INSTR_W-1:0]         Instr_OUT1,
  output logic [ADDR_W-1:0]          PC_OUT0,
  output logic [ADDR_W-1:0]          PC_OUT1,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  free;
  logic [ADDR_W-1:0] pc_q;
  logic [1:0]        enq_n;
  logic [1:0]        valid_slots;
  logic [1:0]        deq_eff;
  fq_entry_t         wr_e0;
  fq_entry_t         wr_e1;
  fq_entry_t         rd_e0;
  fq_entry_t         rd_e1;

  // Space comes from the registered count only, so deq_count never reaches
  // the fetch decision combinationally.
  assign free = CNT_W'(DEPTH) - count_q;

  always_comb begin
    enq_n = 2'd0;
    if (!Request_Alt_PC && fetch_valid_fIM) begin
      if (FETCH_W == 2 && free >= CNT_W'(2)) enq_n = 2'd2;
      else if (free != '0)                   enq_n = 2'd1;
    end
  end

  assign out_valid[0] = (count_q != '0);
  assign out_valid[1] = (DRAIN_W == 2) && (count_q >= CNT_W'(2));
  assign valid_slots  = {1'b0, out_valid[0]} + {1'b0, out_valid[1]};

  // Over-popping is a decode bug; clamp so the queue state stays coherent.
  assign deq_eff = (deq_count > valid_slots) ? valid_slots : deq_count;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else if (Request_Alt_PC) begin
      pc_q    <= Alt_PC;
      count_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      pc_q    <= pc_q + PC_INC * ADDR_W'(enq_n);
      wr_ptr  <= wr_ptr + PTR_W'(enq_n);
      rd_ptr  <= rd_ptr + PTR_W'(deq_eff);
      count_q <= count_q + CNT_W'(enq_n) - CNT_W'(deq_eff);
    end
  end

  always_comb begin
    wr_e0       = '0;
    wr_e1       = '0;
    wr_e0.instr = Instr1_fIM;
    wr_e0.pc    = pc_q;
    wr_e1.instr = Instr2_fIM;
    wr_e1.pc    = pc_q + PC_INC;
  end

  fq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk_sys  (CLK),
    .we0      (enq_n != 2'd0),
    .we1      (enq_n == 2'd2),
    .wr_addr  (wr_ptr),
    .wr_data0 (wr_e0),
    .wr_data1 (wr_e1),
    .rd_addr  (rd_ptr),
    .rd_data0 (rd_e0),
    .rd_data1 (rd_e1)
  );

  assign Instr_address_2IM = pc_q;
  assign count             = count_q;
  assign Instr_OUT0        = out_valid[0] ? rd_e0.instr : '0;
  assign PC_OUT0           = out_valid[0] ? rd_e0.pc    : '0;
  assign Instr_OUT1        = out_valid[1] ? rd_e1.instr : '0;
  assign PC_OUT1           = out_valid[1] ? rd_e1.pc    : '0;

`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if (RESET && !Request_Alt_PC)
      assert (deq_count <= valid_slots)
        else $error("fetch_queue: deq_count %0d exceeds valid slots %0d",
                    deq_count, valid_slots);
  end
`endif

endmodule
